// File: rtl/coeff_fix_convert.sv
// coeff_fix_convert: serial IEEE-754 double -> signed fixed-point converter for
// the five biquad coefficients. A converted set waits in shadow registers and
// is committed to the active outputs as a whole, only on an audio sample strobe.
module coeff_fix_convert #(
    parameter int COEF_W = 24,
    parameter int FRAC   = 22
) (
    input  logic              clk_fast,
    input  logic              rst,
    input  logic [63:0]       b0,
    input  logic [63:0]       b1,
    input  logic [63:0]       b2,
    input  logic [63:0]       a1,
    input  logic [63:0]       a2,
    input  logic              coeff_valid,
    input  logic              sample_strobe,
    input  logic              sat_clr,
    output logic [COEF_W-1:0] b0_q,
    output logic [COEF_W-1:0] b1_q,
    output logic [COEF_W-1:0] b2_q,
    output logic [COEF_W-1:0] a1_q,
    output logic [COEF_W-1:0] a2_q,
    output logic              coeff_update,
    output logic              busy,
    output logic              sat_flag,
    output logic              overrun
);

    // Magnitude width: holds M << COEF_W without wrapping, so the range check is exact.
    localparam int MW = 53 + COEF_W + 2;
    localparam logic [MW-1:0] POS_LIM = {{(MW-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic [MW-1:0] NEG_LIM = POS_LIM + {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] ONE     = {{(MW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, CONV, PEND} state_t;

    state_t            state_q;
    logic [2:0]        idx_q;
    logic [63:0]       cap_q    [5];
    logic [COEF_W-1:0] shadow_q [5];
    logic [COEF_W-1:0] active_q [5];
    logic              sat_pend_q;
    logic              coeff_update_q;
    logic              sat_flag_q;
    logic              overrun_q;

    logic [63:0]       cur;
    logic              sgn;
    logic [10:0]       expo;
    logic [52:0]       mant;
    int                sh;
    int                rsh;
    logic [MW-1:0]     mag;
    logic              big;
    logic [COEF_W-1:0] conv_val;
    logic              conv_sat;

    logic capture;
    logic commit;

    // A new set is accepted everywhere except mid-conversion; commit waits for a strobe in PEND.
    assign capture = coeff_valid && (state_q != CONV);
    assign commit  = (state_q == PEND) && sample_strobe && !coeff_valid;

    // Convert the coefficient selected by idx_q: scale by 2^FRAC, round half away from zero, saturate.
    always_comb begin
        cur      = cap_q[idx_q];
        sgn      = cur[63];
        expo     = cur[62:52];
        mant     = {1'b1, cur[51:0]};
        sh       = int'(expo) - 1075 + FRAC;
        rsh      = -sh;
        mag      = '0;
        big      = 1'b0;
        conv_val = '0;
        conv_sat = 1'b0;
        if (expo == 11'd0) begin
            mag = '0;
        end else if (expo == 11'h7FF) begin
            big = 1'b1;
        end else if (sh >= 0) begin
            if (sh > COEF_W) begin
                big = 1'b1;
            end else begin
                mag = {{(MW-53){1'b0}}, mant} << sh;
            end
        end else if (rsh <= 54) begin
            mag = ({{(MW-53){1'b0}}, mant} + (ONE << (rsh - 1))) >> rsh;
        end
        if (expo != 11'd0) begin
            if (!sgn) begin
                if (big || (mag > POS_LIM)) begin
                    conv_val = {1'b0, {(COEF_W-1){1'b1}}};
                    conv_sat = 1'b1;
                end else begin
                    conv_val = mag[COEF_W-1:0];
                end
            end else begin
                if (big || (mag > NEG_LIM)) begin
                    conv_val = {1'b1, {(COEF_W-1){1'b0}}};
                    conv_sat = 1'b1;
                end else begin
                    conv_val = ~mag[COEF_W-1:0] + {{(COEF_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Control FSM: capture, serial conversion into shadow, atomic commit to active on strobe.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= 3'd0;
            sat_pend_q     <= 1'b0;
            coeff_update_q <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                cap_q[i]    <= '0;
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            coeff_update_q <= 1'b0;
            if (capture) begin
                cap_q[0]   <= b0;
                cap_q[1]   <= b1;
                cap_q[2]   <= b2;
                cap_q[3]   <= a1;
                cap_q[4]   <= a2;
                idx_q      <= 3'd0;
                sat_pend_q <= 1'b0;
                state_q    <= CONV;
            end else begin
                case (state_q)
                    CONV: begin
                        shadow_q[idx_q] <= conv_val;
                        sat_pend_q      <= sat_pend_q | conv_sat;
                        if (idx_q == 3'd4) begin
                            state_q <= PEND;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                    PEND: begin
                        if (sample_strobe) begin
                            for (int i = 0; i < 5; i++) begin
                                active_q[i] <= shadow_q[i];
                            end
                            coeff_update_q <= 1'b1;
                            state_q        <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Sticky status flags: clear on sat_clr, but a same-cycle set takes priority.
    always_ff @(posedge clk_fast or posedge rst) begin
        if (rst) begin
            sat_flag_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sat_flag_q <= (sat_flag_q & ~sat_clr) | (commit & sat_pend_q);
            overrun_q  <= (overrun_q & ~sat_clr) | ((state_q == CONV) & coeff_valid);
        end
    end

    assign b0_q         = active_q[0];
    assign b1_q         = active_q[1];
    assign b2_q         = active_q[2];
    assign a1_q         = active_q[3];
    assign a2_q         = active_q[4];
    assign coeff_update = coeff_update_q;
    assign busy         = (state_q != IDLE);
    assign sat_flag     = sat_flag_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_coeff_fix_convert.sv
// Testbench for coeff_fix_convert: directed spec vectors plus randomized sets
// checked against a real-arithmetic reference conversion.
module tb_coeff_fix_convert;

    logic        clk_fast = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;
    logic        coeff_valid = 1'b0;
    logic        sample_strobe = 1'b0;
    logic        sat_clr = 1'b0;
    logic [23:0] b0_q, b1_q, b2_q, a1_q, a2_q;
    logic        coeff_update, busy, sat_flag, overrun;

    int checks = 0;
    int errors = 0;

    logic [63:0] set_v   [5];
    logic [23:0] exp_q   [5];
    logic [23:0] exp_new [5];
    logic [23:0] exp_a   [5];
    bit          exp_new_sat;

    always #5 clk_fast = ~clk_fast;

    coeff_fix_convert #(.COEF_W(24), .FRAC(22)) dut (
        .clk_fast(clk_fast), .rst(rst),
        .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .coeff_valid(coeff_valid), .sample_strobe(sample_strobe), .sat_clr(sat_clr),
        .b0_q(b0_q), .b1_q(b1_q), .b2_q(b2_q), .a1_q(a1_q), .a2_q(a2_q),
        .coeff_update(coeff_update), .busy(busy), .sat_flag(sat_flag), .overrun(overrun)
    );

    // Reference: value * 2^22, round half away from zero, clamp to Q2.22.
    function automatic logic [23:0] ref_conv(input logic [63:0] d, output bit sat);
        real         x, y, r;
        int          k;
        logic [23:0] t;
        sat = 1'b0;
        if (d[62:52] == 11'd0) return 24'h000000;
        if (d[62:52] == 11'h7FF) begin
            sat = 1'b1;
            return d[63] ? 24'h800000 : 24'h7FFFFF;
        end
        x = $bitstoreal(d);
        y = ((x < 0.0) ? -x : x) * 4194304.0;
        r = (y >= 1.0e12) ? 1.0e12 : $floor(y + 0.5);
        if (!d[63] && r > 8388607.0) begin
            sat = 1'b1;
            return 24'h7FFFFF;
        end
        if (d[63] && r > 8388608.0) begin
            sat = 1'b1;
            return 24'h800000;
        end
        k = $rtoi(r);
        t = k[23:0];
        return d[63] ? (~t + 24'd1) : t;
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] d;
        int          sel;
        sel       = $urandom_range(0, 15);
        d[63]     = 1'($urandom_range(0, 1));
        d[51:32]  = 20'($urandom);
        d[31:0]   = $urandom;
        if (sel == 0)      d[62:52] = 11'd0;
        else if (sel == 1) d[62:52] = 11'h7FF;
        else               d[62:52] = 11'(987 + $urandom_range(0, 40));
        if (sel == 2) d[28:0] = '0;
        return d;
    endfunction

    function automatic logic [23:0] dut_q(input int i);
        case (i)
            0: return b0_q;
            1: return b1_q;
            2: return b2_q;
            3: return a1_q;
            default: return a2_q;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic model_set();
        bit s;
        exp_new_sat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_new[i] = ref_conv(set_v[i], s);
            exp_new_sat = exp_new_sat | s;
        end
    endtask

    task automatic gen_set();
        for (int i = 0; i < 5; i++) set_v[i] = rand_double();
    endtask

    task automatic drive_set();
        b0 = set_v[0]; b1 = set_v[1]; b2 = set_v[2]; a1 = set_v[3]; a2 = set_v[4];
    endtask

    // Drive coeff_valid for one edge (capture edge).
    task automatic start_set();
        drive_set();
        coeff_valid = 1'b1;
        tick();
        coeff_valid = 1'b0;
    endtask

    task automatic strobe();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            exp_q[i] = 24'h0;
            checks++;
            if (dut_q(i) !== 24'h0) begin
                errors++;
                $display("FAIL reset_q%0d got %h want 000000", i, dut_q(i));
            end
        end
        checks++;
        if ({coeff_update, busy, sat_flag, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {coeff_update, busy, sat_flag, overrun});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [23:0] lit [5];
        lit[0] = 24'h400000; lit[1] = 24'h000001; lit[2] = 24'h000000;
        lit[3] = 24'hA00000; lit[4] = 24'h000000;
        set_v[0] = 64'h3FF0000000000000;
        set_v[1] = 64'h3E80000000000000;
        set_v[2] = 64'h3E70000000000000;
        set_v[3] = 64'hBFF8000000000000;
        set_v[4] = 64'h0000000000000001;
        start_set();
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL directed_busy got %b want 1", busy);
        end
        strobe();
        checks++;
        if (coeff_update !== 1'b1) begin
            errors++;
            $display("FAIL directed_update got %b want 1", coeff_update);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_q(i) !== lit[i]) begin
                errors++;
                $display("FAIL directed_q%0d got %h want %h", i, dut_q(i), lit[i]);
            end
            exp_q[i] = lit[i];
        end
        tick();
        checks++;
        if ({coeff_update, busy, sat_flag} !== 3'b000) begin
            errors++;
            $display("FAIL directed_after got %b want 000", {coeff_update, busy, sat_flag});
        end
        $display("directed set committed");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) set_v[i] = 64'h0;
        set_v[1] = 64'h4000000000000000;
        start_set();
        repeat (5) tick();
        strobe();
        checks++;
        if (b1_q !== 24'h7FFFFF || sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got %h/%b want 7fffff/1", b1_q, sat_flag);
        end
        pulse_clr();
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr got %b want 0", sat_flag);
        end
        set_v[1] = 64'hC000000000000000;
        set_v[2] = 64'hFFF0000000000000;
        start_set();
        repeat (5) tick();
        strobe();
        checks++;
        if (b1_q !== 24'h800000) begin
            errors++;
            $display("FAIL sat_negmin got %h want 800000", b1_q);
        end
        checks++;
        if (b2_q !== 24'h800000 || sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_neginf got %h/%b want 800000/1", b2_q, sat_flag);
        end
        pulse_clr();
        set_v[2] = 64'h0;
        start_set();
        repeat (5) tick();
        strobe();
        checks++;
        if (b1_q !== 24'h800000 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_minexact got %h/%b want 800000/0", b1_q, sat_flag);
        end
        for (int i = 0; i < 5; i++) exp_q[i] = dut_q(i) === 24'h800000 ? 24'h800000 : 24'h0;
        $display("saturation sets committed");
    endtask

    task automatic test_random();
        int extra;
        for (int n = 0; n < 30; n++) begin
            gen_set();
            model_set();
            pulse_clr();
            start_set();
            repeat (5) tick();
            extra = $urandom_range(0, 3);
            for (int w = 0; w < extra; w++) begin
                for (int i = 0; i < 5; i++) begin
                    checks++;
                    if (dut_q(i) !== exp_q[i] || coeff_update !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_hold n%0d q%0d got %h/%b want %h/0", n, i, dut_q(i), coeff_update, exp_q[i]);
                    end
                end
                tick();
            end
            strobe();
            checks++;
            if (coeff_update !== 1'b1 || sat_flag !== exp_new_sat) begin
                errors++;
                $display("FAIL rand_upd n%0d got %b/%b want 1/%b", n, coeff_update, sat_flag, exp_new_sat);
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (dut_q(i) !== exp_new[i]) begin
                    errors++;
                    $display("FAIL rand_q n%0d q%0d in %h got %h want %h", n, i, set_v[i], dut_q(i), exp_new[i]);
                end
                exp_q[i] = exp_new[i];
            end
            $display("random set %0d committed sat=%0b", n, exp_new_sat);
        end
    endtask

    task automatic test_latency();
        gen_set();
        model_set();
        start_set();                     // edge 0
        tick();                          // edge 1
        tick();                          // edge 2
        strobe();                        // edge 3: ignored in CONV
        checks++;
        if (coeff_update !== 1'b0 || b0_q !== exp_q[0]) begin
            errors++;
            $display("FAIL lat_early got %b/%h want 0/%h", coeff_update, b0_q, exp_q[0]);
        end
        repeat (6) tick();               // edges 4..9
        checks++;
        if (busy !== 1'b1 || a2_q !== exp_q[4] || coeff_update !== 1'b0) begin
            errors++;
            $display("FAIL lat_hold got %b/%h/%b want 1/%h/0", busy, a2_q, coeff_update, exp_q[4]);
        end
        strobe();                        // edge 10
        checks++;
        if (coeff_update !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lat_commit got %b/%b want 1/0", coeff_update, busy);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_q(i) !== exp_new[i]) begin
                errors++;
                $display("FAIL lat_q%0d got %h want %h", i, dut_q(i), exp_new[i]);
            end
            exp_q[i] = exp_new[i];
        end
        tick();
        checks++;
        if (coeff_update !== 1'b0) begin
            errors++;
            $display("FAIL lat_pulse got %b want 0", coeff_update);
        end
        $display("latency set committed at edge 10");
    endtask

    task automatic test_overrun();
        pulse_clr();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear0 got %b want 0", overrun);
        end
        gen_set();
        model_set();
        for (int i = 0; i < 5; i++) exp_a[i] = exp_new[i];
        start_set();                     // edge 0
        tick();                          // edge 1
        gen_set();
        start_set();                     // edge 2: in CONV
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got %b want 1", overrun);
        end
        repeat (3) tick();               // edges 3..5
        strobe();                        // edge 6
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_q(i) !== exp_a[i] || coeff_update !== 1'b1) begin
                errors++;
                $display("FAIL ovr_first_q%0d got %h/%b want %h/1", i, dut_q(i), coeff_update, exp_a[i]);
            end
            exp_q[i] = exp_a[i];
        end
        // Recapture in PEND with a coincident strobe: newest set wins, no commit.
        gen_set();
        start_set();
        repeat (5) tick();
        gen_set();
        model_set();
        drive_set();
        coeff_valid = 1'b1;
        sample_strobe = 1'b1;
        tick();
        coeff_valid = 1'b0;
        sample_strobe = 1'b0;
        checks++;
        if (coeff_update !== 1'b0 || busy !== 1'b1 || b0_q !== exp_q[0]) begin
            errors++;
            $display("FAIL pend_recap got %b/%b/%h want 0/1/%h", coeff_update, busy, b0_q, exp_q[0]);
        end
        repeat (5) tick();
        strobe();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_q(i) !== exp_new[i] || coeff_update !== 1'b1) begin
                errors++;
                $display("FAIL pend_second_q%0d got %h/%b want %h/1", i, dut_q(i), coeff_update, exp_new[i]);
            end
            exp_q[i] = exp_new[i];
        end
        pulse_clr();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clr got %b want 0", overrun);
        end
        $display("overrun and recapture sets committed");
    endtask

    task automatic test_reset_pend();
        gen_set();
        start_set();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            exp_q[i] = 24'h0;
            checks++;
            if (dut_q(i) !== 24'h0) begin
                errors++;
                $display("FAIL rstpend_q%0d got %h want 000000", i, dut_q(i));
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rstpend_busy got %b want 0", busy);
        end
        tick();
        rst = 1'b0;
        tick();
        strobe();
        checks++;
        if (coeff_update !== 1'b0 || b0_q !== 24'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstpend_after got %b/%h/%b want 0/000000/0", coeff_update, b0_q, busy);
        end
        $display("reset in PEND abandoned set");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_random();
        test_latency();
        test_overrun();
        test_reset_pend();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
